// File: rtl/neural_pkg.sv
// Shared definitions for the neural_processor output path.
// Holds the output_fifo entry layout and the drain FSM state encoding.
package neural_pkg;

  localparam int ENTRY_W = 32;
  localparam int VAL_MSB = 31;
  localparam int VAL_LSB = 16;
  localparam int LT_MSB  = 15;
  localparam int LT_LSB  = 0;

  typedef struct packed {
    logic [VAL_MSB-VAL_LSB:0] val;
    logic [LT_MSB-LT_LSB:0]   lt;
  } entry_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } drain_state_t;

endpackage

// File: rtl/neural_output_drain_if.sv
// Result stream from neural_output_drain to the host.
//   valid : value/last are meaningful
//   ready : host accepts the word when valid & ready
//   value : result value
//   last  : word closes its frame
// master = drain side, slave = host side.
interface neural_output_drain_if #(
  parameter int VAL_W = 16
) ();

  logic             valid;
  logic             ready;
  logic [VAL_W-1:0] value;
  logic             last;

  modport master (
    output valid,
    output value,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  value,
    input  last,
    output ready
  );

endinterface

// File: rtl/neural_output_drain.sv
// neural_output_drain
// Drains the show-ahead output_fifo of neural_processor into a one-word
// output register presented on a valid/ready stream. The lifetime field is
// stripped; expired entries (lifetime == 0) are discarded when DROP_EXPIRED
// is set. Words are grouped into frames of FRAME_LEN, the last word of each
// frame is flagged, and completed frames / dropped entries are counted.
//
// Ports
//   clk          rising-edge clock
//   reset        async assert, active-low
//   enable       allow new pops from the FIFO
//   clear_count  sync clear of frame_count, drop_count and frame index
//   fifo_data    FIFO head entry {value, lifetime}
//   fifo_empty   FIFO empty flag
//   fifo_rd      pop strobe (combinational)
//   out_if       result stream (master)
//   frame_count  completed frames, saturating
//   drop_count   discarded expired entries, saturating
//
// state    | meaning
// ST_EMPTY | output register holds nothing
// ST_FULL  | output register holds a word awaiting acceptance
module neural_output_drain
  import neural_pkg::*;
#(
  parameter int VAL_W        = 16,
  parameter int LT_W         = 16,
  parameter int FRAME_LEN    = 2,
  parameter int CNT_W        = 16,
  parameter int DROP_EXPIRED = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear_count,
  input  logic [VAL_W+LT_W-1:0]   fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  neural_output_drain_if.master   out_if,
  output logic [CNT_W-1:0]        frame_count,
  output logic [CNT_W-1:0]        drop_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  drain_state_t     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] value_q;
  logic             last_q;
  logic             acc;
  logic             drop;
  logic             load;

  assign out_if.valid = (state_q == ST_FULL);
  assign out_if.value = value_q;
  assign out_if.last  = last_q;

  assign acc  = out_if.valid & out_if.ready;
  // Gated by reset so nothing is popped while the block is held in reset.
  assign fifo_rd = reset & enable & ~fifo_empty & ((state_q == ST_EMPTY) | acc);
  assign drop = (DROP_EXPIRED != 0) && (fifo_data[LT_W-1:0] == '0);
  assign load = fifo_rd & ~drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A load always wins: it replaces the word being accepted on the same edge.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_FULL;
    end else if (acc) begin
      state_d = ST_EMPTY;
    end
  end

  // Frame index counts accepted words within the current frame.
  always_comb begin
    idx_d = idx_q;
    if (clear_count) begin
      idx_d = '0;
    end else if (acc) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // The loaded word takes the position after any accept on this same edge,
  // hence the compare against idx_d rather than idx_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      value_q <= fifo_data[VAL_W+LT_W-1:LT_W];
      last_q  <= (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (clear_count) begin
      frame_count <= '0;
    end else if (acc && last_q && (frame_count != '1)) begin
      frame_count <= frame_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (clear_count) begin
      drop_count <= '0;
    end else if (fifo_rd && drop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_neural_output_drain.sv
// Directed bench for neural_output_drain.
//   u0 : defaults (FRAME_LEN=2, DROP_EXPIRED=1)
//   u1 : DROP_EXPIRED=0
//   u2 : FRAME_LEN=1
// Each instance is fed by its own show-ahead FIFO model.
module tb_neural_output_drain;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear_count = 1'b0;
  logic out_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];
  int wp0 = 0, wp1 = 0, wp2 = 0;
  int rp0 = 0, rp1 = 0, rp2 = 0;

  logic        rd0, rd1, rd2;
  logic        emp0, emp1, emp2;
  logic [31:0] fd0, fd1, fd2;
  logic [15:0] fc0, fc1, fc2, dc0, dc1, dc2;

  assign emp0 = (rp0 == wp0);
  assign emp1 = (rp1 == wp1);
  assign emp2 = (rp2 == wp2);
  assign fd0  = mem0[rp0[5:0]];
  assign fd1  = mem1[rp1[5:0]];
  assign fd2  = mem2[rp2[5:0]];

  always @(posedge clk) begin
    if (rd0) rp0 <= rp0 + 1;
    if (rd1) rp1 <= rp1 + 1;
    if (rd2) rp2 <= rp2 + 1;
  end

  neural_output_drain_if #(.VAL_W(16)) oif0 ();
  neural_output_drain_if #(.VAL_W(16)) oif1 ();
  neural_output_drain_if #(.VAL_W(16)) oif2 ();
  assign oif0.ready = out_ready;
  assign oif1.ready = out_ready;
  assign oif2.ready = out_ready;

  neural_output_drain u0 (
    .clk(clk), .reset(reset), .enable(enable), .clear_count(clear_count),
    .fifo_data(fd0), .fifo_empty(emp0), .fifo_rd(rd0), .out_if(oif0),
    .frame_count(fc0), .drop_count(dc0)
  );

  neural_output_drain #(.DROP_EXPIRED(0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .clear_count(clear_count),
    .fifo_data(fd1), .fifo_empty(emp1), .fifo_rd(rd1), .out_if(oif1),
    .frame_count(fc1), .drop_count(dc1)
  );

  neural_output_drain #(.FRAME_LEN(1)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .clear_count(clear_count),
    .fifo_data(fd2), .fifo_empty(emp2), .fifo_rd(rd2), .out_if(oif2),
    .frame_count(fc2), .drop_count(dc2)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input int inst, input logic [31:0] d);
    case (inst)
      0: begin mem0[wp0[5:0]] = d; wp0 = wp0 + 1; end
      1: begin mem1[wp1[5:0]] = d; wp1 = wp1 + 1; end
      default: begin mem2[wp2[5:0]] = d; wp2 = wp2 + 1; end
    endcase
  endtask

  task automatic do_clear();
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b0;
    push(0, 32'h0001_0005);
    repeat (3) step();
    n_cmp++;
    if (rd0 !== 1'b0 || oif0.valid !== 1'b0 || fc0 !== 16'd0 || dc0 !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: got rd=%b valid=%b fc=%0d dc=%0d, expected 0/0/0/0", rd0, oif0.valid, fc0, dc0);
    end
    enable = 1'b0;
    reset = 1'b1;
    step();
    n_cmp++;
    if (rd0 !== 1'b0 || oif0.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_enable: got rd=%b valid=%b, expected 0/0", rd0, oif0.valid);
    end
    enable = 1'b1;
    #1;
    n_cmp++;
    if (rd0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_pop: got rd=%b, expected 1", rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0001 || oif0.last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_word: got valid=%b value=%h last=%b, expected 1/0001/0", oif0.valid, oif0.value, oif0.last);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_drain: got valid=%b, expected 0", oif0.valid);
    end
    do_clear();
  endtask

  task automatic test_streaming();
    logic [15:0] ev [4] = '{16'h0004, 16'h0005, 16'h0006, 16'h0007};
    logic        el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    enable = 1'b1;
    push(0, 32'h0004_0002);
    push(0, 32'h0005_0002);
    push(0, 32'h0006_0001);
    push(0, 32'h0007_0003);
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (oif0.valid !== 1'b1 || oif0.value !== ev[i] || oif0.last !== el[i]) begin
        n_bad++;
        $display("FAIL stream[%0d]: got valid=%b value=%h last=%b, expected 1/%h/%b", i, oif0.valid, oif0.value, oif0.last, ev[i], el[i]);
      end
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || fc0 !== 16'd2 || dc0 !== 16'd0) begin
      n_bad++;
      $display("FAIL stream_end: got valid=%b fc=%0d dc=%0d, expected 0/2/0", oif0.valid, fc0, dc0);
    end
    do_clear();
  endtask

  task automatic test_drop();
    out_ready = 1'b1;
    enable = 1'b1;
    push(0, 32'h0009_0000);
    push(0, 32'h000A_0001);
    push(1, 32'h0009_0000);
    push(1, 32'h000A_0001);
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || dc0 !== 16'd1) begin
      n_bad++;
      $display("FAIL drop_skip: got valid=%b dc=%0d, expected 0/1", oif0.valid, dc0);
    end
    n_cmp++;
    if (oif1.valid !== 1'b1 || oif1.value !== 16'h0009 || oif1.last !== 1'b0) begin
      n_bad++;
      $display("FAIL nodrop_w0: got valid=%b value=%h last=%b, expected 1/0009/0", oif1.valid, oif1.value, oif1.last);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h000A || oif0.last !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_keep: got valid=%b value=%h last=%b, expected 1/000a/0", oif0.valid, oif0.value, oif0.last);
    end
    n_cmp++;
    if (oif1.valid !== 1'b1 || oif1.value !== 16'h000A || oif1.last !== 1'b1) begin
      n_bad++;
      $display("FAIL nodrop_w1: got valid=%b value=%h last=%b, expected 1/000a/1", oif1.valid, oif1.value, oif1.last);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || dc0 !== 16'd1 || fc0 !== 16'd0) begin
      n_bad++;
      $display("FAIL drop_counts: got valid=%b dc=%0d fc=%0d, expected 0/1/0", oif0.valid, dc0, fc0);
    end
    n_cmp++;
    if (oif1.valid !== 1'b0 || dc1 !== 16'd0 || fc1 !== 16'd1) begin
      n_bad++;
      $display("FAIL nodrop_counts: got valid=%b dc=%0d fc=%0d, expected 0/0/1", oif1.valid, dc1, fc1);
    end
    do_clear();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    enable = 1'b1;
    push(0, 32'h0011_0001);
    push(0, 32'h0012_0001);
    push(0, 32'h0013_0001);
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (oif0.valid !== 1'b1 || oif0.value !== 16'h0011 || oif0.last !== 1'b0 || rd0 !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b value=%h last=%b rd=%b, expected 1/0011/0/0", i, oif0.valid, oif0.value, oif0.last, rd0);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (rd0 !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_rd: got rd=%b, expected 1", rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0012 || oif0.last !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_w1: got valid=%b value=%h last=%b, expected 1/0012/1", oif0.valid, oif0.value, oif0.last);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0013 || oif0.last !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_w2: got valid=%b value=%h last=%b, expected 1/0013/0", oif0.valid, oif0.value, oif0.last);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || fc0 !== 16'd1) begin
      n_bad++;
      $display("FAIL bp_end: got valid=%b fc=%0d, expected 0/1", oif0.valid, fc0);
    end
    do_clear();
  endtask

  task automatic test_enable_empty();
    out_ready = 1'b1;
    enable = 1'b1;
    push(0, 32'h0021_0001);
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0021 || rd0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ee_empty_acc: got valid=%b value=%h rd=%b, expected 1/0021/0", oif0.valid, oif0.value, rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || rd0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ee_empty_idle: got valid=%b rd=%b, expected 0/0", oif0.valid, rd0);
    end
    out_ready = 1'b0;
    push(0, 32'h0022_0001);
    step();
    enable = 1'b0;
    push(0, 32'h0023_0001);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (oif0.valid !== 1'b1 || oif0.value !== 16'h0022 || oif0.last !== 1'b1 || rd0 !== 1'b0) begin
        n_bad++;
        $display("FAIL ee_hold[%0d]: got valid=%b value=%h last=%b rd=%b, expected 1/0022/1/0", i, oif0.valid, oif0.value, oif0.last, rd0);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (rd0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ee_disabled_rd: got rd=%b, expected 0", rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b0 || rd0 !== 1'b0 || fc0 !== 16'd1) begin
      n_bad++;
      $display("FAIL ee_delivered: got valid=%b rd=%b fc=%0d, expected 0/0/1", oif0.valid, rd0, fc0);
    end
    enable = 1'b1;
    #1;
    n_cmp++;
    if (rd0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ee_reenable_rd: got rd=%b, expected 1", rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0023 || oif0.last !== 1'b0) begin
      n_bad++;
      $display("FAIL ee_resume: got valid=%b value=%h last=%b, expected 1/0023/0", oif0.valid, oif0.value, oif0.last);
    end
    step();
    do_clear();
  endtask

  task automatic test_clear_reset();
    out_ready = 1'b0;
    enable = 1'b1;
    push(0, 32'h0031_0001);
    push(0, 32'h0032_0001);
    step();
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0032 || oif0.last !== 1'b1) begin
      n_bad++;
      $display("FAIL cr_last_word: got valid=%b value=%h last=%b, expected 1/0032/1", oif0.valid, oif0.value, oif0.last);
    end
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    n_cmp++;
    if (fc0 !== 16'd0 || oif0.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_clear_wins: got fc=%0d valid=%b, expected 0/0", fc0, oif0.valid);
    end
    out_ready = 1'b0;
    push(0, 32'h0033_0001);
    push(0, 32'h0034_0001);
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0033) begin
      n_bad++;
      $display("FAIL cr_full: got valid=%b value=%h, expected 1/0033", oif0.valid, oif0.value);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (oif0.valid !== 1'b0 || oif0.value !== 16'h0000 || rd0 !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_async_reset: got valid=%b value=%h rd=%b, expected 0/0000/0", oif0.valid, oif0.value, rd0);
    end
    @(negedge clk);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (rd0 !== 1'b1) begin
      n_bad++;
      $display("FAIL cr_restart_rd: got rd=%b, expected 1", rd0);
    end
    step();
    n_cmp++;
    if (oif0.valid !== 1'b1 || oif0.value !== 16'h0034 || oif0.last !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_restart_word: got valid=%b value=%h last=%b, expected 1/0034/0", oif0.valid, oif0.value, oif0.last);
    end
    step();
    do_clear();
  endtask

  task automatic test_frame_len1();
    out_ready = 1'b1;
    enable = 1'b1;
    push(2, 32'h0041_0001);
    push(2, 32'h0042_0001);
    step();
    n_cmp++;
    if (oif2.valid !== 1'b1 || oif2.value !== 16'h0041 || oif2.last !== 1'b1) begin
      n_bad++;
      $display("FAIL fl1_w0: got valid=%b value=%h last=%b, expected 1/0041/1", oif2.valid, oif2.value, oif2.last);
    end
    step();
    n_cmp++;
    if (oif2.valid !== 1'b1 || oif2.value !== 16'h0042 || oif2.last !== 1'b1) begin
      n_bad++;
      $display("FAIL fl1_w1: got valid=%b value=%h last=%b, expected 1/0042/1", oif2.valid, oif2.value, oif2.last);
    end
    step();
    n_cmp++;
    if (oif2.valid !== 1'b0 || fc2 !== 16'd2) begin
      n_bad++;
      $display("FAIL fl1_end: got valid=%b fc=%0d, expected 0/2", oif2.valid, fc2);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_drop();
    test_backpressure();
    test_enable_empty();
    test_clear_reset();
    test_frame_len1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
